fetch_prefetch_buffer: RTL
==========================

Name: fetch_prefetch_buffer

Overview:
Instruction-fetch stage for the pipelined processor. It owns the fetch PC and issues word requests to a synchronous instruction memory with 1-cycle read latency. Returned instructions are buffered, with their PCs, in a small FIFO and handed to the decode stage through a valid/ready handshake. A redirect from execute (branch/jump) flushes the FIFO, kills any in-flight request and restarts fetch at the new PC.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
ADDR_W, 32, byte-address width of PC
INSTR_W, 32, instruction width
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_req  output  1  read request this cycle
imem_addr  output  ADDR_W  byte address of request (= fetch PC)
imem_rdata  input  INSTR_W  read data, valid the cycle after imem_req
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  ADDR_W  new fetch PC
id_valid  output  1  instruction available to decode
id_instr  output  INSTR_W  instruction at head
id_pc  output  ADDR_W  PC of id_instr
id_ready  input  1  decode accepts head this cycle
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at edge): fetch PC=RESET_PC, FIFO empty, count=0, in-flight flag=0, kill flag=0. Outputs during/after reset: imem_req=0 in reset cycle, id_valid=0.
- imem_req = !rst && !redirect_valid && (count + inflight) < DEPTH; imem_addr = fetch PC. On issue: PC <= PC+4 (mod 2^ADDR_W, wrap silent), inflight <= 1, captured request PC saved for tagging.
- Response: cycle after issue, if inflight && !kill, push {imem_rdata, tagged PC} into FIFO. Credit check guarantees no overflow; push into full FIFO never occurs.
- Pop: id_valid && id_ready. id_valid = count!=0 (see optional feature). Head data stable while id_valid && !id_ready.
- Simultaneous push and pop: count unchanged, both take effect; works at count=DEPTH (pop frees slot, push fills) and count=1.
- Redirect (priority over all): in that cycle no request issued, pop ignored, FIFO cleared (count=0 next cycle), PC <= redirect_pc, any response arriving that cycle or issued the previous cycle is discarded (kill flag set for one cycle if inflight). First request at redirect_pc issues the cycle after redirect.
- Back-to-back redirects: last one wins; no stale instruction ever reaches id_*.
- redirect_pc low 2 bits passed through unmodified (alignment is decode's problem).
- Throughput: one instruction per cycle steady state with id_ready=1; fetch-to-id_valid latency 2 cycles (issue, response into FIFO, visible next cycle).

Optional Feature:
FETCH_BYPASS_EN: when defined and FIFO empty with a valid (non-killed) response arriving, response is driven combinationally on id_valid/id_instr/id_pc; if id_ready=1 it is consumed without entering the FIFO, else it is pushed normally. Latency after redirect drops from 3 to 2 cycles. Without macro: all responses pass through FIFO; id_* driven purely from registered FIFO head.

Test Plan:
- Reset release, RESET_PC=0, id_ready=1 held, imem returns addr>>2 -> id_pc sequence 0,4,8,12..., id_instr 0,1,2,3, one per cycle after 2-cycle start-up (1 with FETCH_BYPASS_EN).
- id_ready=0 from start -> count reaches 4, imem_req deasserts, no further requests; id_ready=1 -> four entries drain in order 0,4,8,12, fetching resumes at 16.
- Redirect to 0x100 while count=3 and a request in flight -> next cycle count=0, in-flight response dropped, first id_pc=0x100, then 0x104.
- Redirect on two consecutive cycles (0x200 then 0x300) -> no id_pc from 0x200 region delivered; first id_pc=0x300.
- rst asserted mid-stream with count=2 -> next cycle id_valid=0, count=0, imem_addr=RESET_PC; fetch resumes from RESET_PC.
- PC wrap: redirect to 0xFFFFFFFC, id_ready=1 -> id_pc 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/fetch_prefetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads and buffers
// {instr, pc} pairs in a small FIFO for decode. Optional macro FETCH_BYPASS_EN adds an empty-FIFO bypass.
module fetch_prefetch_buffer #(
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]          imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        id_valid,
    output logic [INSTR_W-1:0]          id_instr,
    output logic [ADDR_W-1:0]           id_pc,
    input  logic                        id_ready,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic               kill_q, kill_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic [CNT_W:0]     used;
    logic               rsp_valid;
    logic               fifo_nonempty;
    logic               bypass_sel;
    logic               fifo_push;
    logic               fifo_pop;

    // Credit covers both buffered entries and the response still on its way, so a push never overflows.
    assign used          = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign imem_req      = !rst && !redirect_valid && (used < (CNT_W+1)'(DEPTH));
    assign imem_addr     = pc_q;
    assign rsp_valid     = inflight_q && !kill_q && !redirect_valid;
    assign fifo_nonempty = (count_q != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_sel = !fifo_nonempty && rsp_valid;
`else
    assign bypass_sel = 1'b0;
`endif

    assign id_valid  = fifo_nonempty || bypass_sel;
    assign id_instr  = bypass_sel ? imem_rdata : instr_mem_q[rd_ptr_q];
    assign id_pc     = bypass_sel ? req_pc_q   : pc_mem_q[rd_ptr_q];
    assign count     = count_q;

    assign fifo_pop  = fifo_nonempty && id_ready && !redirect_valid;
    assign fifo_push = rsp_valid && !(bypass_sel && id_ready);

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        kill_d     = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            kill_d   = inflight_q;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req) begin
                pc_d       = pc_q + ADDR_W'(4);
                req_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
            if (fifo_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && fifo_push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule
